// File: rtl/conv_stride_engine.sv
// Streaming k x k strided convolution over an n x n raster frame, two-stage pipeline.
// Build macro CONV_RELU_EN clamps negative results to zero in the output stage.
module conv_stride_engine #(
  parameter int N = 16,
  parameter int Q = 12,
  parameter int n = 4,
  parameter int k = 3,
  parameter int s = 1
) (
  input  logic             clk,
  input  logic             global_rst,
  input  logic             ce,
  input  logic [N-1:0]     activation,
  input  logic [k*k*N-1:0] weight,
  output logic [N-1:0]     data_out,
  output logic             valid_op,
  output logic             end_op
);

  localparam int KK   = k * k;
  localparam int WIN  = (k - 1) * n + k;
  localparam int BUFD = (WIN > 1) ? WIN - 1 : 1;
  localparam int CW   = (n > 1) ? $clog2(n) : 1;
  localparam int PW   = 2 * N;
  localparam int SW   = 2 * N + $clog2(KK);
  localparam int HW   = SW - N + 1;

  // Clamp a full-precision shifted sum into the signed N-bit range.
  function automatic logic [N-1:0] saturate(input logic signed [SW-1:0] v);
    logic [HW-1:0] head;
    head = v[SW-1:N-1];
    if (head == {HW{1'b0}} || head == {HW{1'b1}}) begin
      saturate = v[N-1:0];
    end else if (v[SW-1]) begin
      saturate = {1'b1, {(N-1){1'b0}}};
    end else begin
      saturate = {1'b0, {(N-1){1'b1}}};
    end
  endfunction

  logic [CW-1:0]        row_q, row_d, col_q, col_d;
  int                   row_off_s, col_off_s;
  logic                 first_px_s, last_px_s, win_ok_s;

  logic [N-1:0]         win_q [BUFD];
  logic [N-1:0]         win_d [BUFD];
  logic signed [N-1:0]  win_s [WIN];
  logic signed [N-1:0]  tap_s [KK];

  logic signed [N-1:0]  kern_q [KK];
  logic signed [N-1:0]  kern_d [KK];
  logic signed [N-1:0]  kern_s [KK];

  logic signed [PW-1:0] prod_q [KK];
  logic signed [PW-1:0] prod_d [KK];
  logic                 v1_q, v1_d, e1_q, e1_d;

  logic signed [SW-1:0] sum_s, shift_s;
  logic [N-1:0]         sat_s, res_s;
  logic [N-1:0]         data_q, data_d;
  logic                 valid_q, valid_d, end_q, end_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (ce) begin
      if (col_q == CW'(n - 1)) begin
        col_d = {CW{1'b0}};
        if (row_q == CW'(n - 1)) begin
          row_d = {CW{1'b0}};
        end else begin
          row_d = row_q + CW'(1'b1);
        end
      end else begin
        col_d = col_q + CW'(1'b1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // A window is emitted only when it ends on a stride-aligned position of the current pixel.
  always_comb begin
    row_off_s  = int'(row_q) - (k - 1);
    col_off_s  = int'(col_q) - (k - 1);
    first_px_s = (row_q == {CW{1'b0}}) && (col_q == {CW{1'b0}});
    last_px_s  = (row_q == CW'(n - 1)) && (col_q == CW'(n - 1));
    win_ok_s   = (row_off_s >= 32'sd0) && (col_off_s >= 32'sd0) &&
                 ((row_off_s % s) == 32'sd0) && ((col_off_s % s) == 32'sd0);
  end

  always_comb begin
    win_s[0] = activation;
    for (int i = 1; i < WIN; i++) begin
      win_s[i] = win_q[i-1];
    end
    for (int i = 0; i < BUFD; i++) begin
      if (ce) begin
        win_d[i] = (i == 0) ? activation : win_q[(i > 0) ? i - 1 : 0];
      end else begin
        win_d[i] = win_q[i];
      end
    end
    for (int r = 0; r < k; r++) begin
      for (int c = 0; c < k; c++) begin
        tap_s[r*k+c] = win_s[(k-1-r)*n + (k-1-c)];
      end
    end
  end

  // Pixel (0,0) uses the incoming weights directly so a 1x1 kernel sees the new frame's kernel.
  always_comb begin
    for (int i = 0; i < KK; i++) begin
      kern_s[i] = first_px_s ? weight[i*N +: N] : kern_q[i];
      kern_d[i] = ce ? kern_s[i] : kern_q[i];
      if (ce && win_ok_s) begin
        prod_d[i] = PW'(tap_s[i]) * PW'(kern_s[i]);
      end else begin
        prod_d[i] = prod_q[i];
      end
    end
    v1_d = ce ? win_ok_s : v1_q;
    e1_d = ce ? (win_ok_s && last_px_s) : e1_q;
  end

  always_comb begin
    sum_s = {SW{1'b0}};
    for (int i = 0; i < KK; i++) begin
      sum_s = sum_s + SW'(prod_q[i]);
    end
    shift_s = sum_s >>> Q;
    sat_s   = saturate(shift_s);
`ifdef CONV_RELU_EN
    res_s   = sat_s[N-1] ? {N{1'b0}} : sat_s;
`else
    res_s   = sat_s;
`endif
    data_d  = (ce && v1_q) ? res_s : data_q;
    valid_d = ce ? v1_q : valid_q;
    end_d   = ce ? e1_q : end_q;
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      row_q   <= {CW{1'b0}};
      col_q   <= {CW{1'b0}};
      v1_q    <= 1'b0;
      e1_q    <= 1'b0;
      data_q  <= {N{1'b0}};
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      for (int i = 0; i < BUFD; i++) begin
        win_q[i] <= {N{1'b0}};
      end
      for (int i = 0; i < KK; i++) begin
        kern_q[i] <= {N{1'b0}};
        prod_q[i] <= {PW{1'b0}};
      end
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      v1_q    <= v1_d;
      e1_q    <= e1_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      for (int i = 0; i < BUFD; i++) begin
        win_q[i] <= win_d[i];
      end
      for (int i = 0; i < KK; i++) begin
        kern_q[i] <= kern_d[i];
        prod_q[i] <= prod_d[i];
      end
    end
  end

  assign data_out = data_q;
  assign valid_op = valid_q;
  assign end_op   = end_q;

endmodule

// File: tb/tb_conv_stride_engine.sv
// Self-checking bench: two engine instances (4x4/k3/s1 and 5x5/k3/s2) against a frame-level model.
module tb_conv_stride_engine;
  localparam int N  = 16;
  localparam int Q  = 12;
  localparam int K  = 3;
  localparam int KK = K * K;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             global_rst, ce;
  logic [N-1:0]     activation;
  logic [KK*N-1:0]  weight;
  logic [N-1:0]     data_a, data_b;
  logic             valid_a, valid_b, end_a, end_b;

  conv_stride_engine #(.N(N), .Q(Q), .n(4), .k(K), .s(1)) dut_a (
    .clk(clk), .global_rst(global_rst), .ce(ce), .activation(activation),
    .weight(weight), .data_out(data_a), .valid_op(valid_a), .end_op(end_a));

  conv_stride_engine #(.N(N), .Q(Q), .n(5), .k(K), .s(2)) dut_b (
    .clk(clk), .global_rst(global_rst), .ce(ce), .activation(activation),
    .weight(weight), .data_out(data_b), .valid_op(valid_b), .end_op(end_b));

  typedef struct { logic [N-1:0] d; logic e; int t; } out_t;
  out_t obs_a[$], obs_b[$], exp_q[$];
  logic signed [N-1:0] pix [0:255];
  int     acc_t [0:255];
  longint kern [0:KK-1];
  int checks = 0, failures = 0, ce_edges = 0, stray_end = 0, hold_err = 0;
  logic [N+1:0] prev_a, prev_b;

  // One clock: capture outputs produced by the last edge, then drive the next inputs.
  task automatic tick(input logic c, input logic [N-1:0] a, input logic r);
    out_t o;
    @(negedge clk);
    if (ce === 1'b1 && global_rst === 1'b0) begin
      ce_edges++;
      if (valid_a === 1'b1) begin o.d = data_a; o.e = end_a; o.t = ce_edges; obs_a.push_back(o); end
      if (valid_b === 1'b1) begin o.d = data_b; o.e = end_b; o.t = ce_edges; obs_b.push_back(o); end
    end
    if (ce === 1'b0 && global_rst === 1'b0) begin
      if ({valid_a, end_a, data_a} !== prev_a) hold_err++;
      if ({valid_b, end_b, data_b} !== prev_b) hold_err++;
    end
    if (end_a === 1'b1 && valid_a !== 1'b1) stray_end++;
    if (end_b === 1'b1 && valid_b !== 1'b1) stray_end++;
    prev_a = {valid_a, end_a, data_a};
    prev_b = {valid_b, end_b, data_b};
    global_rst = r;
    ce = c;
    activation = a;
  endtask

  task automatic restart();
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    obs_a.delete();
    obs_b.delete();
    exp_q.delete();
    hold_err = 0;
  endtask

  task automatic set_uniform(input logic [N-1:0] w);
    for (int i = 0; i < KK; i++) begin
      weight[i*N +: N] = w;
      kern[i] = longint'($signed(w));
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < KK; i++) begin
      logic [N-1:0] w;
      w = N'($urandom_range(0, 32'h3FFF)) - 16'h2000;
      weight[i*N +: N] = w;
      kern[i] = longint'($signed(w));
    end
  endtask

  task automatic fill_ramp(input int base, input int nn, input int sh);
    for (int i = 0; i < nn*nn; i++) pix[base+i] = N'(i << sh);
  endtask

  task automatic send_frame(input int nn, input int base, input int stall_at, input bit rnd_stall,
                            input int wchg_at, input logic [KK*N-1:0] wnew);
    for (int i = 0; i < nn*nn; i++) begin
      tick(1'b1, pix[base+i], 1'b0);
      if (i == wchg_at) weight = wnew;
      acc_t[base+i] = ce_edges + 1;
      if (i == stall_at) repeat (3) tick(1'b0, N'($urandom), 1'b0);
      else if (rnd_stall && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick(1'b0, N'($urandom), 1'b0);
    end
  endtask

  task automatic drain();
    repeat (3) tick(1'b1, N'($urandom), 1'b0);
  endtask

  // Reference: every stride-aligned window of the stored frame, computed with 64-bit arithmetic.
  // Each result is due right after the ce edge following acceptance of its window's last pixel.
  function automatic void build_expected(input int nn, input int ss, input int base);
    int no;
    no = (nn - K) / ss + 1;
    for (int orr = 0; orr < no; orr++) begin
      for (int oc = 0; oc < no; oc++) begin
        longint tot;
        int endpx;
        out_t o;
        tot = 0;
        for (int r = 0; r < K; r++)
          for (int c = 0; c < K; c++)
            tot += longint'(pix[base + (orr*ss + r)*nn + oc*ss + c]) * kern[r*K + c];
        tot = tot >>> Q;
        if (tot > (longint'(1) << (N-1)) - 1) tot = (longint'(1) << (N-1)) - 1;
        else if (tot < -(longint'(1) << (N-1))) tot = -(longint'(1) << (N-1));
`ifdef CONV_RELU_EN
        if (tot < 0) tot = 0;
`endif
        endpx = (orr*ss + K - 1)*nn + oc*ss + K - 1;
        o.d = tot[N-1:0];
        o.e = (orr == no - 1) && (oc == no - 1);
        o.t = acc_t[base + endpx] + 1;
        exp_q.push_back(o);
      end
    end
  endfunction

  task automatic test_reset();
    restart();
    checks++;
    if (data_a !== 16'h0000 || valid_a !== 1'b0 || end_a !== 1'b0) begin
      failures++; $display("FAIL reset_a got d=%h v=%b e=%b want d=0000 v=0 e=0", data_a, valid_a, end_a);
    end
    checks++;
    if (data_b !== 16'h0000 || valid_b !== 1'b0 || end_b !== 1'b0) begin
      failures++; $display("FAIL reset_b got d=%h v=%b e=%b want d=0000 v=0 e=0", data_b, valid_b, end_b);
    end
    set_uniform(16'h1000);
    fill_ramp(0, 4, 8);
    for (int i = 0; i < 12; i++) tick(1'b1, pix[i], 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    checks++;
    if (obs_a.size() != 1 || obs_a[0].d !== 16'h2D00) begin
      failures++; $display("FAIL reset_pending got n=%0d want n=1 d=2d00", obs_a.size());
    end
    tick(1'b0, 16'h0000, 1'b0);
    checks++;
    if (data_a !== 16'h0000 || valid_a !== 1'b0 || end_a !== 1'b0) begin
      failures++; $display("FAIL reset_mid got d=%h v=%b e=%b want d=0000 v=0 e=0", data_a, valid_a, end_a);
    end
    obs_a.delete();
    for (int i = 0; i < 6; i++) tick(1'b1, pix[i], 1'b0);
    tick(1'b0, 16'h0000, 1'b0);
    checks++;
    if (obs_a.size() != 0) begin
      failures++; $display("FAIL reset_stale got outputs=%0d want 0", obs_a.size());
    end
  endtask

  task automatic test_ramp(input bit with_stall);
    logic [N-1:0] lit [4] = '{16'h2D00, 16'h3600, 16'h5100, 16'h5A00};
    restart();
    set_uniform(16'h1000);
    fill_ramp(0, 4, 8);
    send_frame(4, 0, with_stall ? 10 : -1, 1'b0, -1, '0);
    drain();
    build_expected(4, 1, 0);
    checks++;
    if (obs_a.size() != exp_q.size()) begin
      failures++; $display("FAIL ramp_count got=%0d want=%0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].d !== lit[i] || obs_a[i].e !== exp_q[i].e || obs_a[i].t != exp_q[i].t) begin
        failures++;
        $display("FAIL ramp_out[%0d] stall=%0d got d=%h e=%b t=%0d want d=%h e=%b t=%0d", i, with_stall,
                 obs_a[i].d, obs_a[i].e, obs_a[i].t, lit[i], exp_q[i].e, exp_q[i].t);
      end
    end
    checks++;
    if (hold_err != 0) begin
      failures++; $display("FAIL ramp_hold got changes=%0d want 0", hold_err);
    end
  endtask

  task automatic test_stride();
    logic [N-1:0] lit [4] = '{16'h0D80, 16'h1200, 16'h2400, 16'h2880};
    restart();
    set_uniform(16'h1000);
    fill_ramp(0, 5, 6);
    send_frame(5, 0, -1, 1'b0, -1, '0);
    build_expected(5, 2, 0);
    for (int f = 1; f < 4; f++) begin
      set_random();
      for (int i = 0; i < 25; i++) pix[f*25 + i] = N'($urandom);
      send_frame(5, f*25, -1, 1'b1, $urandom_range(1, 24), KK*N'($urandom));
      build_expected(5, 2, f*25);
    end
    drain();
    checks++;
    if (obs_b.size() != exp_q.size()) begin
      failures++; $display("FAIL stride_count got=%0d want=%0d", obs_b.size(), exp_q.size());
    end
    for (int i = 0; i < 4 && i < obs_b.size(); i++) begin
      checks++;
      if (obs_b[i].d !== lit[i]) begin
        failures++; $display("FAIL stride_lit[%0d] got=%h want=%h", i, obs_b[i].d, lit[i]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_b.size(); i++) begin
      checks++;
      if (obs_b[i].d !== exp_q[i].d || obs_b[i].e !== exp_q[i].e || obs_b[i].t != exp_q[i].t) begin
        failures++;
        $display("FAIL stride_out[%0d] got d=%h e=%b t=%0d want d=%h e=%b t=%0d", i,
                 obs_b[i].d, obs_b[i].e, obs_b[i].t, exp_q[i].d, exp_q[i].e, exp_q[i].t);
      end
    end
  endtask

  task automatic test_saturate();
    logic [N-1:0] neg_want;
`ifdef CONV_RELU_EN
    neg_want = 16'h0000;
`else
    neg_want = 16'h8000;
`endif
    restart();
    set_uniform(16'h7FFF);
    for (int i = 0; i < 16; i++) begin pix[i] = 16'h7FFF; pix[16+i] = 16'h8000; end
    send_frame(4, 0, -1, 1'b0, -1, '0);
    send_frame(4, 16, -1, 1'b0, -1, '0);
    drain();
    checks++;
    if (obs_a.size() != 8) begin
      failures++; $display("FAIL sat_count got=%0d want=8", obs_a.size());
    end
    for (int i = 0; i < obs_a.size() && i < 8; i++) begin
      checks++;
      if (obs_a[i].d !== ((i < 4) ? 16'h7FFF : neg_want)) begin
        failures++; $display("FAIL sat_out[%0d] got=%h want=%h", i, obs_a[i].d, (i < 4) ? 16'h7FFF : neg_want);
      end
    end
  endtask

  task automatic test_reset_replay();
    restart();
    set_uniform(16'h1000);
    fill_ramp(0, 4, 8);
    for (int i = 0; i < 8; i++) tick(1'b1, pix[i], 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    obs_a.delete();
    send_frame(4, 0, -1, 1'b0, -1, '0);
    drain();
    build_expected(4, 1, 0);
    checks++;
    if (obs_a.size() != 4) begin
      failures++; $display("FAIL replay_count got=%0d want=4", obs_a.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].d !== exp_q[i].d || obs_a[i].e !== exp_q[i].e || obs_a[i].t != exp_q[i].t) begin
        failures++;
        $display("FAIL replay_out[%0d] got d=%h e=%b t=%0d want d=%h e=%b t=%0d", i,
                 obs_a[i].d, obs_a[i].e, obs_a[i].t, exp_q[i].d, exp_q[i].e, exp_q[i].t);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] lit [8] = '{16'h2D00, 16'h3600, 16'h5100, 16'h5A00,
                              16'h5A00, 16'h6C00, 16'h7FFF, 16'h7FFF};
    restart();
    set_uniform(16'h1000);
    fill_ramp(0, 4, 8);
    fill_ramp(16, 4, 8);
    send_frame(4, 0, -1, 1'b0, 5, {KK{16'h2000}});
    build_expected(4, 1, 0);
    for (int i = 0; i < KK; i++) kern[i] = 64'sh2000;
    send_frame(4, 16, -1, 1'b0, -1, {KK{16'h2000}});
    build_expected(4, 1, 16);
    drain();
    checks++;
    if (obs_a.size() != 8) begin
      failures++; $display("FAIL b2b_count got=%0d want=8", obs_a.size());
    end
    for (int i = 0; i < 8 && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].d !== lit[i] || obs_a[i].e !== exp_q[i].e || obs_a[i].t != exp_q[i].t) begin
        failures++;
        $display("FAIL b2b_out[%0d] got d=%h e=%b t=%0d want d=%h e=%b t=%0d", i,
                 obs_a[i].d, obs_a[i].e, obs_a[i].t, lit[i], exp_q[i].e, exp_q[i].t);
      end
    end
  endtask

  task automatic test_random();
    restart();
    for (int f = 0; f < 5; f++) begin
      set_random();
      for (int i = 0; i < 16; i++) pix[f*16 + i] = N'($urandom);
      send_frame(4, f*16, -1, 1'b1, $urandom_range(1, 15), KK*N'($urandom));
      build_expected(4, 1, f*16);
    end
    drain();
    checks++;
    if (obs_a.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", obs_a.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++) begin
      checks++;
      if (obs_a[i].d !== exp_q[i].d || obs_a[i].e !== exp_q[i].e || obs_a[i].t != exp_q[i].t) begin
        failures++;
        $display("FAIL rand_out[%0d] got d=%h e=%b t=%0d want d=%h e=%b t=%0d", i,
                 obs_a[i].d, obs_a[i].e, obs_a[i].t, exp_q[i].d, exp_q[i].e, exp_q[i].t);
      end
    end
    checks++;
    if (hold_err != 0 || stray_end != 0) begin
      failures++; $display("FAIL rand_hold got changes=%0d stray_end=%0d want 0 0", hold_err, stray_end);
    end
  endtask

  initial begin
    global_rst = 1'b1;
    ce = 1'b0;
    activation = '0;
    weight = '0;
    test_reset();
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_stride();
    test_saturate();
    test_reset_replay();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
